add_accu: RTL and testbench

Streaming temporal accumulator: the consuming end of the `add_multi` adder tree. It accepts a stream of partial sums framed by a `last` flag, accumulates each fold (1..MAX_FOLD terms) into a wide register, and delivers one result per fold over a valid/ready handshake with a 2-entry output buffer. It sits between the MVU spatial adder tree and the output/threshold stage, reducing over time what `add_multi` reduces over space.

---
 rtl/add_accu_pkg.sv | 27 ++
 rtl/add_accu_obuf.sv | 49 ++++
 rtl/add_accu.sv | 96 +++++++++
 tb/tb_add_accu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_accu_pkg.sv
// Width helpers shared by the add_accu accumulator and its output buffer.
// Used to size the accumulator so that a full fold of extreme terms never wraps.
package add_accu_pkg;

    // Smallest width that holds v, as two's complement when sgn is set.
    function automatic int bitwidth(longint v, bit sgn);
        int w = 64;
        for (int i = 62; i >= 1; i--) begin
            if (sgn) begin
                if (v >= -(longint'(1) <<< (i - 1)) && v < (longint'(1) <<< (i - 1)))
                    w = i;
            end else if (v < (longint'(1) << i)) begin
                w = i;
            end
        end
        return w;
    endfunction

    function automatic int sumwidth(int folds, int argw, longint lo, longint hi);
        bit sgn = (lo < 0);
        int wlo = bitwidth(folds * lo, sgn);
        int whi = bitwidth(folds * hi, sgn);
        int w   = (wlo > whi) ? wlo : whi;
        return (w > argw) ? w : argw;
    endfunction

endpackage

// File: rtl/add_accu_obuf.sv
// Two-entry valid/ready FIFO; prdy depends only on registered occupancy.
module add_accu_obuf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pvld,
    output logic         prdy,
    input  logic [W-1:0] pdat,
    output logic         cvld,
    input  logic         crdy,
    output logic [W-1:0] cdat
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   occ;
    logic         push;
    logic         pop;

    assign prdy = (occ != 2'd2);
    assign cvld = (occ != 2'd0);
    assign cdat = head;
    assign push = pvld && prdy;
    assign pop  = cvld && crdy;

    // A pop from a full buffer cannot coincide with a push, since prdy is low then.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            if (pop) begin
                if (occ == 2'd2)
                    head <= tail;
                else if (push)
                    head <= pdat;
            end else if (push) begin
                if (occ == 2'd0)
                    head <= pdat;
                else
                    tail <= pdat;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/add_accu.sv
// Streaming temporal accumulator: sums each last-framed fold of terms and
// hands one {sum, count} result per fold to a 2-entry output buffer.
module add_accu
    import add_accu_pkg::*;
#(
    parameter  int ARG_WIDTH = 8,
    parameter  int ARG_LO    = -128,
    parameter  int ARG_HI    = 127,
    parameter  int MAX_FOLD  = 64,
    localparam int ACC_WIDTH = sumwidth(MAX_FOLD, ARG_WIDTH, ARG_LO, ARG_HI),
    localparam int CNT_WIDTH = $clog2(MAX_FOLD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ivld,
    output logic                 irdy,
    input  logic [ARG_WIDTH-1:0] iarg,
    input  logic                 ilast,
    output logic                 ovld,
    input  logic                 ordy,
    output logic [ACC_WIDTH-1:0] osum,
    output logic [CNT_WIDTH-1:0] ocnt,
    output logic                 oerr
);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic [CNT_WIDTH-1:0] cnt;
    } accu_out_t;

    localparam bit SIGNED = (ARG_LO < 0);
    localparam logic [CNT_WIDTH:0] MAX_CNT = (CNT_WIDTH + 1)'(MAX_FOLD);

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 first;
    logic                 buf_rdy;
    logic                 xfer;
    logic [ACC_WIDTH-1:0] arg_ext;
    logic [ACC_WIDTH-1:0] sum_nxt;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic                 ovf;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    accu_out_t            push_dat;
    accu_out_t            head_dat;

    assign irdy     = buf_rdy && !rst;
    assign xfer     = ivld && irdy;
    assign arg_ext  = SIGNED ? ACC_WIDTH'($signed(iarg)) : ACC_WIDTH'(iarg);
    assign sum_nxt  = (first ? '0 : acc) + arg_ext;
    assign cnt_base = first ? '0 : cnt;

    // The count is computed one bit wider so a term past MAX_FOLD is visible.
    assign cnt_inc  = {1'b0, cnt_base} + (CNT_WIDTH + 1)'(1);
    assign ovf      = (cnt_inc > MAX_CNT);
    assign cnt_nxt  = ovf ? MAX_CNT[CNT_WIDTH-1:0] : cnt_inc[CNT_WIDTH-1:0];

    assign push_dat.sum = sum_nxt;
    assign push_dat.cnt = cnt_nxt;
    assign osum         = head_dat.sum;
    assign ocnt         = head_dat.cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            first <= 1'b1;
            oerr  <= 1'b0;
        end else if (xfer) begin
            if (ovf)
                oerr <= 1'b1;
            if (ilast) begin
                first <= 1'b1;
            end else begin
                acc   <= sum_nxt;
                cnt   <= cnt_nxt;
                first <= 1'b0;
            end
        end
    end

    add_accu_obuf #(
        .W($bits(accu_out_t))
    ) u_obuf (
        .clk  (clk),
        .rst  (rst),
        .pvld (xfer && ilast),
        .prdy (buf_rdy),
        .pdat (push_dat),
        .cvld (ovld),
        .crdy (ordy),
        .cdat (head_dat)
    );

endmodule

// File: tb/tb_add_accu.sv
// Scoreboard bench for add_accu: a signed MAX_FOLD=4 instance carries the stream
// tests, an unsigned 0..16 MAX_FOLD=8 instance checks the no-wrap case.
module tb_add_accu;

    logic       clk = 1'b0;
    logic       rst;

    logic       s_ivld, s_irdy, s_ilast, s_ovld, s_ordy, s_oerr;
    logic [7:0] s_iarg;
    logic [9:0] s_osum;
    logic [2:0] s_ocnt;

    logic       u_ivld, u_irdy, u_ilast, u_ovld, u_ordy, u_oerr;
    logic [4:0] u_iarg;
    logic [7:0] u_osum;
    logic [3:0] u_ocnt;

    typedef struct packed {
        logic [9:0] sum;
        logic [2:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         stalls = 0;
    logic [9:0] m_acc = '0;
    int         m_cnt = 0;
    bit         m_first = 1'b1;

    always #5 clk = ~clk;

    add_accu #(.ARG_WIDTH(8), .ARG_LO(-128), .ARG_HI(127), .MAX_FOLD(4)) dut_s (
        .clk(clk), .rst(rst), .ivld(s_ivld), .irdy(s_irdy), .iarg(s_iarg), .ilast(s_ilast),
        .ovld(s_ovld), .ordy(s_ordy), .osum(s_osum), .ocnt(s_ocnt), .oerr(s_oerr)
    );

    add_accu #(.ARG_WIDTH(5), .ARG_LO(0), .ARG_HI(16), .MAX_FOLD(8)) dut_u (
        .clk(clk), .rst(rst), .ivld(u_ivld), .irdy(u_irdy), .iarg(u_iarg), .ilast(u_ilast),
        .ovld(u_ovld), .ordy(u_ordy), .osum(u_osum), .ocnt(u_ocnt), .oerr(u_oerr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one term on the signed instance and records the expected fold result once accepted.
    task automatic applyStimulus(input int v, input bit last);
        int         waited = 0;
        bit         accepted = 1'b0;
        logic [7:0] vb;
        logic [9:0] nsum;
        int         ncnt;
        vb      = 8'(v);
        s_ivld  = 1'b1;
        s_iarg  = vb;
        s_ilast = last;
        while (!accepted) begin
            @(negedge clk);
            if (s_irdy) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checkOutput("irdyTimeout", 0, 1);
                    s_ivld  = 1'b0;
                    s_ilast = 1'b0;
                    return;
                end
            end
        end
        stalls += waited;
        s_ivld  = 1'b0;
        s_ilast = 1'b0;
        nsum = (m_first ? 10'd0 : m_acc) + 10'($signed(vb));
        ncnt = (m_first ? 0 : m_cnt) + 1;
        if (ncnt > 4)
            ncnt = 4;
        if (last) begin
            sb.push_back('{sum: nsum, cnt: 3'(ncnt)});
            m_first = 1'b1;
        end else begin
            m_acc   = nsum;
            m_cnt   = ncnt;
            m_first = 1'b0;
        end
    endtask

    // Every output transfer of the signed instance is matched against the oldest expected fold.
    always @(negedge clk) begin
        if (!rst && s_ovld && s_ordy) begin
            if (sb.size() == 0) begin
                checkOutput("spuriousResult", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sbSum", s_osum, e.sum);
                checkOutput("sbCnt", s_ocnt, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b1;
        s_ivld = 1'b0; s_iarg = '0; s_ilast = 1'b0; s_ordy = 1'b1;
        u_ivld = 1'b0; u_iarg = '0; u_ilast = 1'b0; u_ordy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstIrdy", s_irdy, 0);
        checkOutput("rstOvld", s_ovld, 0);
        checkOutput("rstOsum", s_osum, 0);
        checkOutput("rstOcnt", s_ocnt, 0);
        checkOutput("rstOerr", s_oerr, 0);
        checkOutput("rstUOvld", u_ovld, 0);
        rst = 1'b0;
        #1;
        checkOutput("postRstIrdy", s_irdy, 1);
        checkOutput("postRstUIrdy", u_irdy, 1);

        // Unsigned: eight terms of 16 must reach 128 in an 8-bit accumulator without wrapping.
        for (int i = 0; i < 8; i++) begin
            u_ivld  = 1'b1;
            u_iarg  = 5'd16;
            u_ilast = (i == 7);
            @(negedge clk);
            checkOutput("uIrdy", u_irdy, 1);
            @(posedge clk);
            #1;
        end
        u_ivld  = 1'b0;
        u_ilast = 1'b0;
        checkOutput("uOvld", u_ovld, 1);
        checkOutput("uOsum", u_osum, 128);
        checkOutput("uOcnt", u_ocnt, 8);
        checkOutput("uOerr", u_oerr, 0);

        // Signed fold with one-cycle latency to ovld.
        applyStimulus(5, 0);
        applyStimulus(-3, 0);
        applyStimulus(100, 0);
        applyStimulus(-128, 1);
        checkOutput("foldOvld", s_ovld, 1);
        checkOutput("foldOsum", s_osum, 10'h3E6);
        checkOutput("foldOcnt", s_ocnt, 4);
        checkOutput("foldOerr", s_oerr, 0);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back single-term folds.
        stalls = 0;
        for (int i = 0; i < 100; i++)
            applyStimulus(int'($urandom_range(0, 255)) - 128, 1);
        checkOutput("irdyStays", stalls, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("drainSingles", sb.size(), 0);

        // Backpressure: two buffered folds fill the buffer and block input.
        s_ordy = 1'b0;
        applyStimulus(1, 0);
        applyStimulus(2, 1);
        applyStimulus(3, 0);
        applyStimulus(4, 1);
        checkOutput("bpIrdyLow", s_irdy, 0);
        checkOutput("bpOvld", s_ovld, 1);
        checkOutput("bpOsum", s_osum, 3);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bpOsumHold", s_osum, 3);
        checkOutput("bpOcntHold", s_ocnt, 2);
        checkOutput("bpIrdyStillLow", s_irdy, 0);
        s_ordy = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bpIrdyBack", s_irdy, 1);
        applyStimulus(5, 0);
        applyStimulus(6, 1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("drainBp", sb.size(), 0);

        // Fold overflow: five terms into a MAX_FOLD=4 accumulator.
        for (int i = 0; i < 4; i++)
            applyStimulus(127, 0);
        checkOutput("ovfErrBefore", s_oerr, 0);
        applyStimulus(127, 1);
        checkOutput("ovfErr", s_oerr, 1);
        checkOutput("ovfOcnt", s_ocnt, 4);
        checkOutput("ovfOsum", s_osum, 635);
        applyStimulus(1, 1);
        checkOutput("ovfErrSticky", s_oerr, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("drainOvf", sb.size(), 0);

        // Reset in the middle of a fold discards the partial terms.
        applyStimulus(10, 0);
        applyStimulus(20, 0);
        rst = 1'b1;
        #1;
        checkOutput("midRstIrdy", s_irdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_first = 1'b1;
        #1;
        checkOutput("midRstOvld", s_ovld, 0);
        checkOutput("midRstOsum", s_osum, 0);
        checkOutput("midRstOcnt", s_ocnt, 0);
        checkOutput("midRstOerr", s_oerr, 0);
        checkOutput("midRstIrdyBack", s_irdy, 1);
        applyStimulus(7, 0);
        applyStimulus(9, 1);
        checkOutput("afterRstOsum", s_osum, 16);
        checkOutput("afterRstOcnt", s_ocnt, 2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("drainFinal", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
